// File: rtl/types_pkg.sv
// Shared pipeline types; the fetch additions are the buffer entry, reset PC and PC step.
package types_pkg;

    localparam int DATA_BUS = 32;

    typedef logic [DATA_BUS-1:0] data_bus_t;

    typedef struct packed {
        data_bus_t instr;
    } fetch_entry_t;

    localparam data_bus_t FETCH_RESET_PC = 32'h0000_0000;
    localparam data_bus_t PC_STEP        = 32'd4;

    function automatic data_bus_t align_word(input data_bus_t addr);
        return {addr[DATA_BUS-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order instruction buffer: synchronous FIFO with flush, count and empty/full flags.
module fetch_fifo
    import types_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Flush wins over any push or pop in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues credit-limited word requests, buffers responses and
// hands {instr, pc, pc+4} to decode; a redirect flushes the buffer and discards in-flight words.
module fetch_stage
    import types_pkg::*;
#(
    parameter data_bus_t RESET_PC = FETCH_RESET_PC,
    parameter int        DEPTH    = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    output logic      imem_req_o,
    output data_bus_t imem_addr_o,
    input  logic      imem_gnt_i,
    input  logic      imem_rvalid_i,
    input  data_bus_t imem_rdata_i,
    input  logic      redirect_i,
    input  data_bus_t redirect_pc_i,
    output logic      id_valid_o,
    input  logic      id_ready_i,
    output data_bus_t id_instr_o,
    output data_bus_t id_pc_o,
    output data_bus_t id_pc_plus4_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    data_bus_t     fetch_pc;
    data_bus_t     head_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic [CW:0]   credit_used;
    logic          fire;
    logic          push;
    logic          pop;
    fetch_entry_t  push_entry;
    fetch_entry_t  head_entry;

    // Credit uses registered state only, so id_ready_i/imem_rvalid_i never reach imem_req_o.
    assign credit_used = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_o  = rst_n && !redirect_i && (credit_used < (CW+1)'(DEPTH));
    assign imem_addr_o = align_word(fetch_pc);

    assign fire = imem_req_o && imem_gnt_i;
    assign push = imem_rvalid_i && (discard == '0) && !redirect_i;
    assign pop  = id_valid_o && id_ready_i && !redirect_i;

    assign push_entry.instr = imem_rdata_i;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_i),
        .head      (head_entry),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= align_word(RESET_PC);
            head_pc     <= align_word(RESET_PC);
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding + CW'(fire) - CW'(imem_rvalid_i);
            if (redirect_i) begin
                fetch_pc <= align_word(redirect_pc_i);
                head_pc  <= align_word(redirect_pc_i);
                // Every word still in flight is stale, minus the one arriving right now.
                discard  <= outstanding - CW'(imem_rvalid_i);
            end else begin
                if (fire) fetch_pc <= fetch_pc + PC_STEP;
                if (pop)  head_pc  <= head_pc + PC_STEP;
                if (imem_rvalid_i && (discard != '0)) discard <= discard - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && full));
            assert (credit_used <= (CW+1)'(DEPTH));
            assert (discard <= outstanding);
        end
    end

    assign id_valid_o    = !empty;
    assign id_instr_o    = head_entry.instr;
    assign id_pc_o       = head_pc;
    assign id_pc_plus4_o = head_pc + PC_STEP;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an in-order memory model and an epoch-tagged scoreboard.
module tb_fetch_stage;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_pc_plus4_o;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] epc;
        int          due;
        int          ep;
    } req_t;

    req_t        pend[$];
    logic [31:0] expq[$];
    int          cyc;
    int          lat;
    int          epoch;
    bit          rand_gnt;
    logic [31:0] model_pc;
    int          compared;
    int          mismatched;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .id_valid_o    (id_valid_o),
        .id_ready_i    (id_ready_i),
        .id_instr_o    (id_instr_o),
        .id_pc_o       (id_pc_o),
        .id_pc_plus4_o (id_pc_plus4_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic step();
        bit   rv;
        bit   rq;
        bit   gt;
        bit   xf;
        req_t h;
        h  = '{32'h0, 32'h0, 0, 0};
        rv = (pend.size() != 0) && (pend[0].due <= cyc);
        if (rv) h = pend[0];
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? mem_word(h.addr) : 32'hDEAD_BEEF;
        imem_gnt_i    = rand_gnt ? ($urandom_range(0, 3) != 0) : 1'b1;
        #1;
        check("imem_req", {31'b0, imem_req_o},
              {31'b0, !redirect_i && ((expq.size() + pend.size()) < DEPTH)});
        if (imem_req_o) check("imem_addr", imem_addr_o, model_pc);
        check("id_valid", {31'b0, id_valid_o}, {31'b0, expq.size() != 0});
        if (id_valid_o && expq.size() != 0) begin
            check("id_pc", id_pc_o, expq[0]);
            check("id_pc_plus4", id_pc_plus4_o, expq[0] + 32'd4);
            check("id_instr", id_instr_o, mem_word(expq[0]));
        end
        rq = imem_req_o;
        gt = imem_gnt_i;
        xf = id_valid_o && id_ready_i;
        if (rv) void'(pend.pop_front());
        if (redirect_i) begin
            expq.delete();
            epoch++;
            model_pc = {redirect_pc_i[31:2], 2'b00};
        end else begin
            if (xf && expq.size() != 0) void'(expq.pop_front());
            if (rv && h.ep == epoch) expq.push_back(h.epc);
            if (rq && gt) begin
                pend.push_back('{imem_addr_o, model_pc, cyc + lat, epoch});
                model_pc = model_pc + 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_i    = 1'b1;
        redirect_pc_i = pc;
        step();
        redirect_i    = 1'b0;
    endtask

    initial begin
        compared      = 0;
        mismatched    = 0;
        cyc           = 0;
        lat           = 1;
        epoch         = 0;
        rand_gnt      = 1'b0;
        model_pc      = 32'h0;
        rst_n         = 1'b0;
        imem_gnt_i    = 1'b1;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        id_ready_i    = 1'b1;

        repeat (2) @(negedge clk);
        check("reset_req", {31'b0, imem_req_o}, 32'h0);
        check("reset_valid", {31'b0, id_valid_o}, 32'h0);
        rst_n = 1'b1;

        // Streaming with 1-cycle memory
        repeat (12) step();

        // Decode stall fills the buffer, then drains
        id_ready_i = 1'b0;
        repeat (10) step();
        id_ready_i = 1'b1;
        repeat (8) step();

        // 3-cycle memory, redirect with words in flight
        lat = 3;
        repeat (6) step();
        do_redirect(32'h0000_0100);
        repeat (12) step();

        // Redirect coinciding with rvalid and pop
        lat = 1;
        repeat (6) step();
        do_redirect(32'h0000_0180);
        repeat (8) step();

        // Two redirects one cycle apart, then back-to-back
        lat = 2;
        repeat (5) step();
        do_redirect(32'h0000_0200);
        step();
        do_redirect(32'h0000_0300);
        repeat (10) step();
        do_redirect(32'h0000_0400);
        do_redirect(32'h0000_0500);
        repeat (10) step();

        // Misaligned target and PC wrap
        lat = 1;
        do_redirect(32'h0000_1002);
        repeat (6) step();
        do_redirect(32'hFFFF_FFF4);
        repeat (8) step();

        // Random grant, ready and redirects
        rand_gnt = 1'b1;
        lat      = 2;
        for (int i = 0; i < 60; i++) begin
            id_ready_i    = ($urandom_range(0, 2) != 0);
            redirect_i    = ($urandom_range(0, 11) == 0);
            redirect_pc_i = $urandom;
            step();
        end
        redirect_i = 1'b0;
        id_ready_i = 1'b1;
        rand_gnt   = 1'b0;
        lat        = 1;
        repeat (6) step();

        // Asynchronous reset mid-stream
        #2 rst_n = 1'b0;
        imem_rvalid_i = 1'b0;
        #1;
        check("midrst_req", {31'b0, imem_req_o}, 32'h0);
        check("midrst_valid", {31'b0, id_valid_o}, 32'h0);
        pend.delete();
        expq.delete();
        epoch++;
        model_pc = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
